// File: rtl/colour_map_pipe.sv
// colour_map_pipe: 3-stage iteration-count to RGB mapper with frame-synchronous config shadowing
module colour_map_pipe #(
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ITER_W-1:0] cfg_max_iter_i,
  input  logic [1:0]        cfg_mode_i,
  input  logic [7:0]        cfg_offset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ITER_W-1:0] iter_i,
  input  logic              sof_i,
  input  logic              eol_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [23:0]       pixel_o,
  output logic              sof_o,
  output logic              eol_o
);
  logic              w_adv, w_acc, w_int;
  logic [ITER_W-1:0] r_max, w_max;
  logic [1:0]        r_mode, w_mode;
  logic [7:0]        r_off, w_off;
  logic [5:0]        w_p;
  logic [7:0]        w_s, w_v, w_inv;
  logic [23:0]       w_pix;
  logic              r1_v, r1_int, r1_sof, r1_eol;
  logic [7:0]        r1_s, r1_off;
  logic [1:0]        r1_mode;
  logic              r2_v, r2_int, r2_sof, r2_eol;
  logic [7:0]        r2_val, r2_inv;
  logic [1:0]        r2_mode;
  assign w_adv      = !out_valid_o || out_ready_i;
  assign in_ready_o = w_adv;
  assign w_acc      = in_valid_i && w_adv;
  // a sof beat already uses the config it carries
  assign w_max  = sof_i ? cfg_max_iter_i : r_max;
  assign w_mode = sof_i ? cfg_mode_i : r_mode;
  assign w_off  = sof_i ? cfg_offset_i : r_off;
  always_comb begin
    w_p = '0;
    for (int k = 0; k < ITER_W; k++) w_p = w_max[k] ? 6'(k) : w_p;
  end
  assign w_s   = (w_p >= 6'd7) ? 8'(iter_i >> (w_p - 6'd7)) : 8'(iter_i << (6'd7 - w_p));
  assign w_int = (w_max == '0) || (iter_i == w_max);
  assign w_v   = r1_s + r1_off;
  assign w_inv = (w_v <= 8'd50) ? 8'd200 - {w_v[5:0], 2'b00} : 8'd0;
  assign w_pix = r2_int          ? 24'h0 :
                 r2_mode == 2'd0 ? {r2_val, r2_val, r2_inv} :
                 r2_mode == 2'd1 ? {r2_val, r2_inv, r2_val} :
                 r2_mode == 2'd2 ? {r2_inv, r2_val, r2_val} :
                                   {r2_val, r2_val, r2_val};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_max <= '0; r_mode <= '0; r_off <= '0;
      r1_v <= 1'b0; r1_int <= 1'b0; r1_sof <= 1'b0; r1_eol <= 1'b0;
      r1_s <= '0; r1_off <= '0; r1_mode <= '0;
      r2_v <= 1'b0; r2_int <= 1'b0; r2_sof <= 1'b0; r2_eol <= 1'b0;
      r2_val <= '0; r2_inv <= '0; r2_mode <= '0;
      out_valid_o <= 1'b0; pixel_o <= '0; sof_o <= 1'b0; eol_o <= 1'b0;
    end else begin
      if (w_acc && sof_i) begin
        r_max  <= cfg_max_iter_i;
        r_mode <= cfg_mode_i;
        r_off  <= cfg_offset_i;
      end
      if (w_adv) begin
        r1_v        <= in_valid_i;
        r1_int      <= w_int;
        r1_sof      <= sof_i;
        r1_eol      <= eol_i;
        r1_s        <= w_s;
        r1_off      <= w_off;
        r1_mode     <= w_mode;
        r2_v        <= r1_v;
        r2_int      <= r1_int;
        r2_sof      <= r1_sof;
        r2_eol      <= r1_eol;
        r2_val      <= w_v;
        r2_inv      <= w_inv;
        r2_mode     <= r1_mode;
        out_valid_o <= r2_v;
        pixel_o     <= w_pix;
        sof_o       <= r2_sof;
        eol_o       <= r2_eol;
      end
    end
  end
endmodule

// File: tb/tb_colour_map_pipe.sv
// tb_colour_map_pipe: directed vector table plus backpressure and reset sequences
module tb_colour_map_pipe;
  logic        clk = 1'b0, rst;
  logic [15:0] cfg_max_iter_i, iter_i;
  logic [1:0]  cfg_mode_i;
  logic [7:0]  cfg_offset_i;
  logic        in_valid_i, in_ready_o, sof_i, eol_i;
  logic        out_valid_o, out_ready_i, sof_o, eol_o;
  logic [23:0] pixel_o;
  typedef struct {
    logic        sof, eol;
    logic [15:0] max;
    logic [1:0]  mode;
    logic [7:0]  off;
    logic [15:0] iter;
    logic [23:0] pix;
  } vec_t;
  vec_t        tv[17];
  int          checks = 0, errors = 0, sent = 0, got = 0;
  logic        acc, seen;
  logic [7:0]  s8, inv8;
  logic [25:0] q[$];
  logic [25:0] exp_beat;

  colour_map_pipe #(.ITER_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_max_iter_i(cfg_max_iter_i), .cfg_mode_i(cfg_mode_i),
    .cfg_offset_i(cfg_offset_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .iter_i(iter_i), .sof_i(sof_i), .eol_i(eol_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .pixel_o(pixel_o), .sof_o(sof_o), .eol_o(eol_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic beat(input vec_t v, input int idx);
    int lat;
    cfg_max_iter_i = v.max; cfg_mode_i = v.mode; cfg_offset_i = v.off;
    in_valid_i = 1'b1; iter_i = v.iter; sof_i = v.sof; eol_i = v.eol;
    #1 chk($sformatf("in_ready[%0d]", idx), in_ready_o, 1);
    @(posedge clk);
    #1 in_valid_i = 1'b0; sof_i = 1'b0; eol_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 8) begin
      @(posedge clk);
      #1 lat++;
    end
    chk($sformatf("latency[%0d]", idx), lat, 3);
    chk($sformatf("pixel[%0d]", idx), pixel_o, v.pix);
    chk($sformatf("sof[%0d]", idx), sof_o, v.sof);
    chk($sformatf("eol[%0d]", idx), eol_o, v.eol);
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{1'b1, 1'b0, 16'd256,    2'd0, 8'd0,   16'd100,    24'h323200};
    tv[1]  = '{1'b0, 1'b0, 16'd5,      2'd3, 8'd7,   16'd10,     24'h0505B4};
    tv[2]  = '{1'b0, 1'b1, 16'd0,      2'd0, 8'd0,   16'd256,    24'h000000};
    tv[3]  = '{1'b1, 1'b0, 16'd100,    2'd1, 8'd0,   16'd10,     24'h147814};
    tv[4]  = '{1'b1, 1'b0, 16'd0,      2'd0, 8'd0,   16'd0,      24'h000000};
    tv[5]  = '{1'b1, 1'b0, 16'd256,    2'd2, 8'd250, 16'd100,    24'h182C2C};
    tv[6]  = '{1'b1, 1'b0, 16'd256,    2'd3, 8'd0,   16'd100,    24'h323232};
    tv[7]  = '{1'b1, 1'b0, 16'd256,    2'd0, 8'd0,   16'd100,    24'h323200};
    tv[8]  = '{1'b0, 1'b0, 16'd256,    2'd3, 8'd0,   16'd100,    24'h323200};
    tv[9]  = '{1'b1, 1'b0, 16'd256,    2'd3, 8'd0,   16'd100,    24'h323232};
    tv[10] = '{1'b1, 1'b1, 16'd100,    2'd0, 8'd0,   16'd200,    24'h909000};
    tv[11] = '{1'b1, 1'b0, 16'd256,    2'd0, 8'd0,   16'd102,    24'h333300};
    tv[12] = '{1'b1, 1'b0, 16'd256,    2'd0, 8'd0,   16'd0,      24'h0000C8};
    tv[13] = '{1'b1, 1'b0, 16'd128,    2'd0, 8'd0,   16'd127,    24'h7F7F00};
    tv[14] = '{1'b1, 1'b0, 16'hFFFF,   2'd0, 8'd0,   16'h8000,   24'h808000};
    tv[15] = '{1'b1, 1'b0, 16'd256,    2'd0, 8'd0,   16'd300,    24'h969600};
    tv[16] = '{1'b0, 1'b0, 16'd256,    2'd0, 8'd0,   16'd5,      24'h000000};
    rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1; sof_i = 1'b0; eol_i = 1'b0;
    iter_i = '0; cfg_max_iter_i = '0; cfg_mode_i = '0; cfg_offset_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_pixel", pixel_o, 0);
    chk("rst_sideband", {sof_o, eol_o}, 0);
    chk("rst_in_ready", in_ready_o, 1);
    for (int i = 0; i < 16; i++) beat(tv[i], i);
    for (int c = 0; c < 40 && got < 8; c++) begin
      out_ready_i = (c >= 6);
      in_valid_i = (sent < 8);
      iter_i = 16'(20 + 2 * sent); sof_i = (sent == 0); eol_i = (sent % 3 == 2);
      cfg_max_iter_i = 16'd256; cfg_mode_i = 2'd0; cfg_offset_i = 8'd0;
      #1;
      if (c >= 3 && c <= 5) begin
        chk("bp_in_ready", in_ready_o, 0);
        chk("bp_hold_valid", out_valid_o, 1);
        chk("bp_hold_pixel", pixel_o, 24'h0A0AA0);
      end
      if (c == 5) chk("bp_accepted", sent, 3);
      if (out_valid_o && out_ready_i) begin
        if (q.size() > 0) begin
          exp_beat = q.pop_front();
          chk($sformatf("bp_beat[%0d]", got), {sof_o, eol_o, pixel_o}, exp_beat);
        end else begin
          checks++; errors++;
          $display("FAIL bp_extra_beat: got %0h expected none", pixel_o);
        end
        got++;
      end
      acc = in_valid_i && in_ready_o;
      @(posedge clk);
      if (acc) begin
        s8 = 8'(10 + sent); inv8 = 8'(160 - 4 * sent);
        q.push_back({sof_i, eol_i, s8, s8, inv8});
        sent++;
      end
      #1;
    end
    in_valid_i = 1'b0; sof_i = 1'b0; eol_i = 1'b0; out_ready_i = 1'b1;
    chk("bp_count", got, 8);
    chk("bp_queue_empty", q.size(), 0);
    for (int k = 0; k < 3; k++) begin
      in_valid_i = 1'b1; sof_i = (k == 0); iter_i = 16'(100 + k);
      cfg_max_iter_i = 16'd256; cfg_mode_i = 2'd0;
      @(posedge clk);
      #1;
    end
    in_valid_i = 1'b0; sof_i = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid_o, 0);
    chk("mid_rst_pixel", pixel_o, 0);
    chk("mid_rst_in_ready", in_ready_o, 1);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1 seen = seen | out_valid_o;
    end
    chk("mid_rst_no_partial", seen, 0);
    beat(tv[16], 16);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/colour_map_pipe.md
Name: colour_map_pipe

Overview:
- Pipelined, parametrised successor to the combinational iteration-to-RGB colour mapper.
- Sits between the escape-time iteration engine output stream and the pixel/video packer.
- Takes one iteration count per beat over a valid/ready handshake and emits a packed 24-bit RGB pixel three cycles later.
- Adds the following over the combinational version:
  - generic iteration width;
  - a grayscale mode;
  - a palette-cycling offset;
  - frame-synchronous configuration shadowing;
  - saturating inverse ramp;
  - start-of-frame and end-of-line sideband pass-through.

Parameters:
- ITER_W, 16, width of iteration counts and max_iter; legal range 8..32.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cfg_max_iter_i  in  ITER_W  staged max iteration count
- cfg_mode_i  in  2  staged palette mode
- cfg_offset_i  in  8  staged palette rotation offset
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  input beat accepted when in_valid_i && in_ready_o
- iter_i  in  ITER_W  iteration count of this pixel
- sof_i  in  1  first pixel of frame
- eol_i  in  1  last pixel of line
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  downstream ready
- pixel_o  out  24  {r[23:16], g[15:8], b[7:0]}
- sof_o  out  1  sof_i delayed with its pixel
- eol_o  out  1  eol_i delayed with its pixel

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high.
  - On rst:
    - all stage valids = 0
    - out_valid_o = 0, pixel_o = 0, sof_o = 0, eol_o = 0
    - active config: max_iter = 0, mode = 0, offset = 0
  - In-flight beats are discarded. A reset mid-stream emits no partial beats.
- Handshake:
  - advance = !out_valid_o || out_ready_i.
  - in_ready_o = advance (combinational).
  - When advance is 1, all three stages shift together. When it is 0, every stage holds.
  - pixel_o, sof_o and eol_o are stable while out_valid_o && !out_ready_i.
  - Bubbles are not compressed.
  - Throughput is 1 beat/cycle. Latency from acceptance to out_valid_o is 3 cycles when not stalled.
- Config shadowing:
  - Active config loads from the cfg_* ports on an accepted beat with sof_i = 1.
  - That beat and all later beats use the new config.
  - cfg_* changes at any other time have no effect.
- Stage 1 (register iter and sideband, compute normalise shift):
  - p = index of the highest set bit of the active max_iter.
  - If p >= 7: t = iter >> (p-7).
  - Otherwise: t = (iter << (7-p)) truncated to ITER_W bits.
  - s = t[7:0].
  - interior = (max_iter == 0) || (iter == max_iter).
  - iter > max_iter is not interior; it is mapped normally with truncation.
- Stage 2:
  - v = (s + offset) mod 256.
  - inv = (v <= 50) ? 200 - 4*v : 0. This is saturating, with no 8-bit wrap.
- Stage 3 (select channels):
  - mode 0: (v, v, inv)
  - mode 1: (v, inv, v)
  - mode 2: (inv, v, v)
  - mode 3: (v, v, v), grayscale
  - If interior: pixel = 0x000000 regardless of mode and offset.
- Mode and offset are captured with each beat's config, so a reconfiguration at sof never affects earlier in-flight beats.

Test Plan:
- Basic mapping, stream of 3 beats with out_ready_i = 1:
  - Setup: cfg max_iter = 256, mode = 0, offset = 0, first beat sof = 1.
  - Beats: iter = 100, 10, 256.
  - Required pixels: 0x323200, 0x0505B4, 0x000000.
  - Each pixel appears exactly 3 cycles after acceptance; sof_o = 1 on the first pixel only.
- Left-shift normalise:
  - Setup: sof beat, max_iter = 100, mode = 1, iter = 10.
  - Required: pixel 0x147814 (s = 20, inv = 120).
  - Then max_iter = 0 on the next sof beat with iter = 0: required 0x000000.
- Offset and mode 2:
  - Setup: sof beat, max_iter = 256, offset = 250, mode = 2, iter = 100.
  - Required: v = 44, pixel 0x182C2C.
  - Then a mode 3 sof beat with iter = 100, offset = 0: required 0x323232.
- Config shadowing:
  - Stimulus: change cfg_mode_i from 0 to 3 mid-frame on a beat with sof = 0, iter = 100, max_iter = 256.
  - Required: pixel stays 0x323200.
  - The next sof beat with the same iter must give 0x323232.
- Backpressure:
  - Stimulus: in_valid_i held high with incrementing iter, out_ready_i low for 6 cycles.
  - Required: exactly 3 beats accepted, then in_ready_o = 0 with pixel_o held stable.
  - After release, all beats emerge in order with no loss or duplication; eol_o is aligned with its pixel.
- Reset mid-stream:
  - Stimulus: assert rst for 1 cycle with 3 beats in flight.
  - Required: next cycle out_valid_o = 0, pixel_o = 0, in_ready_o = 1.
  - A subsequent beat without sof (iter = 5) outputs 0x000000, because the active max_iter is 0.
